// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, datapath widths and FSM state type shared by the alu_arbiter slice.
package alu_pkg;
  localparam int ALU_W = 8;
  localparam int RES_W = 9;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MUL  = 4'b0010;
  localparam logic [3:0] ALU_SHL  = 4'b0011;
  localparam logic [3:0] ALU_SHR  = 4'b0100;
  localparam logic [3:0] ALU_ROL  = 4'b0101;
  localparam logic [3:0] ALU_ROR  = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_NOR  = 4'b1010;
  localparam logic [3:0] ALU_NAND = 4'b1011;
  localparam logic [3:0] ALU_XNOR = 4'b1100;
  localparam logic [3:0] ALU_GT   = 4'b1101;
  localparam logic [3:0] ALU_EQ   = 4'b1110;
  localparam logic [3:0] ALU_INC  = 4'b1111;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu.sv
// alu: combinational 8-bit ALU with a 9-bit result whose bit 8 carries carry/borrow/overflow.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [3:0]       sel,
  output logic [RES_W-1:0] result
);
  logic [2*ALU_W-1:0] prod;
  assign prod = {8'b0, a} * {8'b0, b};
  always_comb begin
    result = '0;
    case (sel)
      ALU_ADD:  result = {1'b0, a} + {1'b0, b};
      ALU_SUB:  result = {1'b0, a} - {1'b0, b};
      ALU_MUL:  result = {|prod[15:8], prod[7:0]};
      ALU_SHL:  result = {a, 1'b0};
      ALU_SHR:  result = {a[0], 1'b0, a[7:1]};
      ALU_ROL:  result = {1'b0, a[6:0], a[7]};
      ALU_ROR:  result = {1'b0, a[0], a[7:1]};
      ALU_AND:  result = {1'b0, a & b};
      ALU_OR:   result = {1'b0, a | b};
      ALU_XOR:  result = {1'b0, a ^ b};
      ALU_NOR:  result = {1'b0, ~(a | b)};
      ALU_NAND: result = {1'b0, ~(a & b)};
      ALU_XNOR: result = {1'b0, ~(a ^ b)};
      ALU_GT:   result = {8'b0, a > b};
      ALU_EQ:   result = {8'b0, a == b};
      ALU_INC:  result = {1'b0, a} + 9'd1;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant searching upward from ptr with wrap; ALU_ARB_PRIO_EN makes bit 0 win outright.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic [NREQ-1:0] mask;
  logic [IDW:0]    j;
`ifdef ALU_ARB_PRIO_EN
  assign mask = {req[NREQ-1:1], 1'b0};
`else
  assign mask = req;
`endif
  // Walk offsets high to low so the closest valid index after ptr is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IDW+1)'(k);
      if (j >= (IDW+1)'(NREQ)) j = j - (IDW+1)'(NREQ);
      if (mask[j[IDW-1:0]]) begin
        idx = j[IDW-1:0];
        any = 1'b1;
      end
    end
`ifdef ALU_ARB_PRIO_EN
    if (req[0]) begin
      idx = '0;
      any = 1'b1;
    end
`endif
    grant = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu among NREQ valid/ready requesters (IDLE->EXEC->RESP).
// ALU_ARB_PRIO_EN: requester 0 gets fixed priority and its grants leave the pointer alone.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  input  logic [4*NREQ-1:0]     req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RES_W-1:0]      rsp_result,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);
  state_t state, state_n;
  logic [IDW-1:0] ptr, ptr_n, ptr_rr, g;
  logic [NREQ-1:0] grant;
  logic any, take;
  logic [ALU_W-1:0] op_a, op_b;
  logic [3:0] op_sel;
  logic [RES_W-1:0] alu_res;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req(req_valid), .ptr(ptr), .grant(grant), .idx(g), .any(any)
  );
  alu u_alu (.a(op_a), .b(op_b), .sel(op_sel), .result(alu_res));
  assign take      = state == IDLE && any && !rst;
  assign req_ready = take ? grant : '0;
  assign rsp_valid = state == RESP;
  assign busy      = state != IDLE;
  assign ptr_rr    = g == IDW'(NREQ - 1) ? '0 : g + 1'b1;
`ifdef ALU_ARB_PRIO_EN
  assign ptr_n = g == '0 ? ptr : ptr_rr;
`else
  assign ptr_n = ptr_rr;
`endif
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = any ? EXEC : IDLE;
    else if (state == EXEC) state_n = RESP;
    else state_n = rsp_ready ? IDLE : RESP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      rsp_result <= '0;
      rsp_id     <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        op_a   <= req_a[{g, 3'b000} +: ALU_W];
        op_b   <= req_b[{g, 3'b000} +: ALU_W];
        op_sel <= req_sel[{g, 2'b00} +: 4];
        rsp_id <= g;
        ptr    <= ptr_n;
      end
      if (state == EXEC) rsp_result <= alu_res;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors plus a per-cycle behavioural model of the arbitrated ALU.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid = 4'b1111, req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [15:0] req_sel = '0;
  logic rsp_valid, rsp_ready = 1'b1, busy;
  logic [8:0] rsp_result;
  logic [1:0] rsp_id;
  int ntests = 0, nfail = 0;
  always #5 clk = ~clk;
  alu_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_id(rsp_id), .busy(busy)
  );
  function automatic int alu_ref(int a, int b, int op);
    int p;
    p = a * b;
    case (op)
      0: return a + b;
      1: return (a - b) & 511;
      2: return (p > 255 ? 256 : 0) | (p & 255);
      3: return (a * 2) & 511;
      4: return ((a & 1) << 8) | (a >> 1);
      5: return ((a << 1) & 255) | (a >> 7);
      6: return (a >> 1) | ((a & 1) << 7);
      7: return a & b;
      8: return a | b;
      9: return a ^ b;
      10: return ~(a | b) & 255;
      11: return ~(a & b) & 255;
      12: return ~(a ^ b) & 255;
      13: return a > b ? 1 : 0;
      14: return a == b ? 1 : 0;
      default: return a + 1;
    endcase
  endfunction
  function automatic int pick(logic [3:0] v, int p);
`ifdef ALU_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input int i, input int a, input int b, input int op);
    req_a[8*i +: 8] = a[7:0];
    req_b[8*i +: 8] = b[7:0];
    req_sel[4*i +: 4] = op[3:0];
  endtask
  int m_phase = 0, m_ptr = 0, m_id = 0, m_res = 0, m_pend = 0;
  always @(negedge clk) begin
    int g, er;
    g = (m_phase == 0 && !rst) ? pick(req_valid, m_ptr) : -1;
    er = g >= 0 ? 1 << g : 0;
    chk("req_ready", {28'b0, req_ready}, er);
    chk("rsp_valid", {31'b0, rsp_valid}, m_phase == 2 ? 1 : 0);
    chk("busy", {31'b0, busy}, m_phase != 0 ? 1 : 0);
    chk("rsp_result", {23'b0, rsp_result}, m_res);
    chk("rsp_id", {30'b0, rsp_id}, m_id);
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_id = 0; m_res = 0;
    end else if (m_phase == 0) begin
      if (g >= 0) begin
        m_pend = alu_ref(int'(req_a[8*g +: 8]), int'(req_b[8*g +: 8]), int'(req_sel[4*g +: 4]));
        m_id = g;
`ifdef ALU_ARB_PRIO_EN
        if (g != 0) m_ptr = (g + 1) % NREQ;
`else
        m_ptr = (g + 1) % NREQ;
`endif
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_res = m_pend;
      m_phase = 2;
    end else if (rsp_ready) m_phase = 0;
  end
  initial begin
    int gr[$], at[$], rs[$];
    int e3g[5], e3r[5], e6[4];
`ifdef ALU_ARB_PRIO_EN
    e3g = '{0, 0, 0, 0, 0};
    e3r = '{100, 100, 100, 100, 100};
    e6 = '{0, 0, 0, 0};
`else
    e3g = '{0, 1, 2, 3, 0};
    e3r = '{100, 3, 'h140, 'h102, 100};
    e6 = '{3, 0, 3, 0};
`endif
    step(); step();
    @(negedge clk);
    chk("rst_req_ready", {28'b0, req_ready}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    step(); rst = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("rst_result", {23'b0, rsp_result}, 0);
    chk("rst_id", {30'b0, rsp_id}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    step(); req_valid = 4'b0001; drive(0, 240, 15, 0);
    @(negedge clk);
    chk("t1_ready", {28'b0, req_ready}, 1);
    step(); req_valid = '0;
    @(negedge clk);
    chk("t1_exec_busy", {31'b0, busy}, 1);
    chk("t1_exec_nvalid", {31'b0, rsp_valid}, 0);
    step();
    @(negedge clk);
    chk("t1_valid", {31'b0, rsp_valid}, 1);
    chk("t1_result", {23'b0, rsp_result}, 255);
    chk("t1_id", {30'b0, rsp_id}, 0);
    step();
    @(negedge clk);
    chk("t1_idle", {31'b0, busy}, 0);
    step(); req_valid = 4'b0100; drive(2, 255, 255, 0);
    @(negedge clk);
    chk("t2_ready", {28'b0, req_ready}, 4);
    step(); req_valid = '0;
    step();
    @(negedge clk);
    chk("t2_result", {23'b0, rsp_result}, 510);
    chk("t2_id", {30'b0, rsp_id}, 2);
    step(); step();
    rst = 1'b1;
    step(); rst = 1'b0;
    drive(0, 200, 100, 1); drive(1, 'h0F, 'hF3, 7); drive(2, 16, 20, 2); drive(3, 'h81, 0, 3);
    req_valid = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (req_ready[i]) begin gr.push_back(i); at.push_back(c); end
      if (rsp_valid) rs.push_back(int'(rsp_result));
      step();
    end
    req_valid = '0;
    chk("t3_grants", gr.size(), 5);
    chk("t3_rsps", rs.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < gr.size()) begin
        chk("t3_order", gr[i], e3g[i]);
        chk("t3_spacing", at[i], 3 * i);
      end
      if (i < rs.size()) chk("t3_result", rs[i], e3r[i]);
    end
    step(); step(); step();
    rsp_ready = 1'b0; req_valid = 4'b0010; drive(1, 100, 50, 1);
    @(negedge clk);
    chk("t4_ready", {28'b0, req_ready}, 2);
    step(); req_valid = 4'b1000; drive(3, 7, 9, 14);
    step();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_hold_valid", {31'b0, rsp_valid}, 1);
      chk("t4_hold_result", {23'b0, rsp_result}, 50);
      chk("t4_hold_id", {30'b0, rsp_id}, 1);
      chk("t4_hold_noready", {28'b0, req_ready}, 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t4_last_valid", {31'b0, rsp_valid}, 1);
    step();
    @(negedge clk);
    chk("t4_idle", {31'b0, busy}, 0);
    chk("t4_next_grant", {28'b0, req_ready}, 8);
    step(); req_valid = '0;
    step(); step(); step();
    req_valid = 4'b0100; drive(2, 1, 2, 0);
    @(negedge clk);
    chk("t5_ready", {28'b0, req_ready}, 4);
    step(); rst = 1'b1; req_valid = '0;
    @(negedge clk);
    chk("t5_exec_busy", {31'b0, busy}, 1);
    step(); rst = 1'b0; req_valid = 4'b1010; drive(1, 3, 4, 0); drive(3, 9, 9, 0);
    @(negedge clk);
    chk("t5_idle", {31'b0, busy}, 0);
    chk("t5_norsp", {31'b0, rsp_valid}, 0);
    chk("t5_lowest", {28'b0, req_ready}, 2);
    step(); req_valid = '0;
    step();
    @(negedge clk);
    chk("t5_result", {23'b0, rsp_result}, 7);
    chk("t5_id", {30'b0, rsp_id}, 1);
    step(); step();
    gr.delete();
    drive(0, 5, 6, 0); drive(3, 10, 3, 1);
    req_valid = 4'b1001;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (req_ready[i]) gr.push_back(i);
      step();
    end
    req_valid = '0;
    chk("t6_grants", gr.size(), 4);
    for (int i = 0; i < 4 && i < gr.size(); i++) chk("t6_order", gr[i], e6[i]);
    step(); step(); step();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational 8-bit `alu` datapath between `NREQ` requesters. Each requester presents two operands and a 4-bit opcode over a valid/ready handshake. The block grants one requester at a time by round-robin, registers the operands into the ALU, and returns the registered 9-bit result with the winner's ID. It sits between the requester-side units and the one `alu` instance, and is the only driver of that instance's inputs.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `IDW`, 2, requester ID width, equal to `$clog2(NREQ)`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  NREQ  per-requester request strobe
- `req_ready`  out  NREQ  per-requester accept; at most one bit high (one-hot)
- `req_a`  in  8*NREQ  packed A operands; requester i occupies bits [8i+7:8i]
- `req_b`  in  8*NREQ  packed B operands, same packing as `req_a`
- `req_sel`  in  4*NREQ  packed opcodes; requester i occupies bits [4i+3:4i]
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts the result
- `rsp_result`  out  9  ALU result; bit 8 holds carry/overflow
- `rsp_id`  out  IDW  ID of the requester that owns `rsp_result`
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - Compute grant `g` among set `req_valid` bits, searching upward from the round-robin pointer `ptr` with wrap-around.
  - `req_ready[g]` is combinational, high only for the granted requester.
  - On handshake: capture `req_a[g]`, `req_b[g]`, `req_sel[g]` into operand registers; set `rsp_id <= g`; `ptr <= (g+1) mod NREQ`; go to EXEC.
  - With no valid request, stay in IDLE; `ptr` is unchanged.
- **EXEC**
  - The ALU is driven only from the operand registers.
  - `rsp_result <= ALU_Result`; go to RESP.
- **RESP**
  - `rsp_valid = 1`.
  - `rsp_result` and `rsp_id` hold stable until `rsp_ready`.
  - `rsp_valid && rsp_ready` → IDLE.
- `req_ready` is all-zero in EXEC and RESP. A requester must keep `req_valid` and its operands stable until `req_ready` is seen.
- Dropping `req_valid` while not granted is legal and has no effect.
- Opcodes pass through unmodified. Result width is always 9 bits and never truncated (255+255 = 510).
- Non-power-of-two `NREQ`: pointer wraps from NREQ-1 to 0.
- Reset values:
  - state = IDLE, `ptr` = 0, operand registers = 0
  - `rsp_result` = 0, `rsp_id` = 0, `rsp_valid` = 0, `req_ready` = 0 during reset, `busy` = 0
- Reset mid-operation: the in-flight op is discarded with no response. The next cycle is IDLE with `ptr` = 0.

## Timing
- Cycle 0 (IDLE): request handshake.
- Cycle 1 (EXEC): ALU evaluates the registered operands.
- Cycle 2: `rsp_valid` = 1. Latency from request handshake to `rsp_valid` is 2 cycles.
- If `rsp_ready` is high in cycle 2, the FSM is in IDLE in cycle 3. The next grant can handshake in cycle 3.
- Peak throughput: one op per 3 cycles.
- Backpressure: each cycle `rsp_ready` is low extends RESP by one cycle.
- `req_ready` depends combinationally on `req_valid` and `ptr`. No other output is combinational from inputs.

## Configuration
- `ALU_ARB_PRIO_EN`
  - Defined: requester 0 has fixed highest priority. If `req_valid[0]` is set in IDLE, it wins regardless of `ptr`, and `ptr` is left unchanged after a requester-0 grant. The remaining requesters rotate round-robin among themselves.
  - Undefined: pure round-robin across all `NREQ` requesters.

## Structure
- Package `alu_pkg`:
  - opcode localparams (`ALU_ADD` = 4'b0000, and the remaining opcodes)
  - `ALU_W` = 8 and `RES_W` = 9
  - FSM state enum type
- Sub-module `rr_arbiter`: request vector plus pointer in, one-hot grant plus encoded index out. The optional priority override sits inside `rr_arbiter`.
- `alu_arbiter` instantiates the existing `alu` once.

## Test plan
- Single request, `req_a[0]`=240, `req_b[0]`=15, opcode 0000 → `rsp_valid` 2 cycles after handshake; `rsp_result`=255, `rsp_id`=0.
- Requester 2: 255 + 255, add → `rsp_result`=510 (0x1FE), `rsp_id`=2.
- All 4 requesters valid continuously, `rsp_ready` tied high, macro off → grant order 0,1,2,3,0 at handshakes spaced 3 cycles apart; `req_ready` one-hot every cycle.
- Hold `rsp_ready` low for 5 cycles in RESP → `rsp_result` and `rsp_id` stable, `req_ready` = 0 throughout, IDLE 1 cycle after `rsp_ready` rises.
- Assert `rst` during EXEC → next cycle IDLE, `rsp_valid` = 0, no response ever issued for that op; first grant after reset goes to the lowest valid index.
- Macro on, requesters 0 and 3 always valid → requester 0 wins every arbitration.
